// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game of Life array engine.
package gol_pkg;

  // Sequencing states of the array controller.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } gol_state_e;

  // Birth on exactly three neighbours, survival on two or three.
  function automatic logic gol_rule(input logic [3:0] n, input logic cur);
    return (n == 4'd3) || ((n == 4'd2) && cur);
  endfunction

  // Live-neighbour count of the eight surrounding cells.
  function automatic logic [3:0] gol_popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

  // Flat index of the neighbour at (r+dr, c+dc). With wrap set, off-grid
  // coordinates fold around the torus; without it they yield -1.
  function automatic int gol_nbr_idx(input int r, input int c,
                                     input int dr, input int dc,
                                     input int width, input int height,
                                     input logic wrap);
    int rr;
    int cc;
    int res;
    rr = r + dr;
    cc = c + dc;
    if ((rr < 0) || (rr >= height) || (cc < 0) || (cc >= width)) begin
      if (wrap) begin
        rr  = (rr + height) % height;
        cc  = (cc + width) % width;
        res = rr * width + cc;
      end else begin
        res = -1;
      end
    end else begin
      res = rr * width + cc;
    end
    return res;
  endfunction

endpackage

// File: rtl/gol_next_gen.sv
// Combinational next-generation calculator for a WIDTH x HEIGHT grid.
// Each cell gathers its eight neighbours (edge neighbours are gated by the
// boundary mode) and applies the life rule.
module gol_next_gen
  import gol_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  logic [WIDTH*HEIGHT-1:0] i_cur,
  input  logic                    i_wrap_mode,
  output logic [WIDTH*HEIGHT-1:0] o_next
);

  for (genvar r = 0; r < HEIGHT; r++) begin : g_row
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
      logic [7:0] w_nb;

      // k walks the 3x3 window in raster order, skipping the centre.
      for (genvar k = 0; k < 8; k++) begin : g_nb
        localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
        localparam int DC = ((k == 0) || (k == 3) || (k == 5)) ? -1 :
                            (((k == 1) || (k == 6)) ? 0 : 1);
        localparam int WI = gol_nbr_idx(r, c, DR, DC, WIDTH, HEIGHT, 1'b1);
        localparam int BI = gol_nbr_idx(r, c, DR, DC, WIDTH, HEIGHT, 1'b0);

        if (BI >= 0) begin : g_inside
          assign w_nb[k] = i_cur[WI];
        end else begin : g_edge
          // Off-grid neighbour: only visible when the grid is a torus.
          assign w_nb[k] = i_wrap_mode & i_cur[WI];
        end
      end

      assign o_next[r*WIDTH+c] = gol_rule(gol_popcount8(w_nb), i_cur[r*WIDTH+c]);
    end
  end

endmodule

// File: rtl/gol_array.sv
// Game of Life engine: cell register, run/step/halt controller, generation
// counter and stable/extinct flags. The display reads cells directly.
//
// Control contract: load has priority over run/step; step is a one-cycle
// pulse honoured only in IDLE; run is a level honoured in IDLE and RUN.
// HALTED is left only through load or reset.
module gol_array
  import gol_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10,
  parameter int GEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [WIDTH*HEIGHT-1:0] init_cells,
  input  logic                    wrap_mode,
  input  logic                    run,
  input  logic                    step,
  input  logic                    halt_on_stable,
  output logic [WIDTH*HEIGHT-1:0] cells,
  output logic [GEN_W-1:0]        generation,
  output logic                    stable,
  output logic                    extinct,
  output logic                    halted,
  output logic [1:0]              dbg_state
);

  localparam int N = WIDTH * HEIGHT;

  logic [N-1:0]     r_cells;
  logic [GEN_W-1:0] r_gen;
  logic             r_stable;
  logic             r_extinct;
  gol_state_e       r_state;

  logic [N-1:0]     w_next;
  gol_state_e       w_state_nxt;
  logic             w_advance;
  logic             w_same;
  logic             w_zero;

  gol_next_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_next_gen (
    .i_cur       (r_cells),
    .i_wrap_mode (wrap_mode),
    .o_next      (w_next)
  );

  assign w_same = (w_next == r_cells);
  assign w_zero = (w_next == '0);

  // Next-state and advance decision; auto-halt is judged on the advance taken this edge.
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (run) begin
          w_advance   = 1'b1;
          w_state_nxt = RUN;
        end else if (step) begin
          w_advance   = 1'b1;
        end
      end
      RUN: begin
        if (run) begin
          w_advance   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_advance && halt_on_stable && (w_same || w_zero)) begin
      w_state_nxt = HALTED;
    end
  end

  // State, cells, counter and flags; reset beats load, load beats advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cells   <= '0;
      r_gen     <= '0;
      r_stable  <= 1'b0;
      r_extinct <= 1'b1;
    end else if (load) begin
      r_state   <= IDLE;
      r_cells   <= init_cells;
      r_gen     <= '0;
      r_stable  <= 1'b0;
      r_extinct <= (init_cells == '0);
    end else begin
      r_state <= w_state_nxt;
      if (w_advance) begin
        r_cells   <= w_next;
        r_stable  <= w_same;
        r_extinct <= w_zero;
        if (!(&r_gen)) begin
          r_gen <= r_gen + GEN_W'(1);
        end
      end
    end
  end

  assign cells      = r_cells;
  assign generation = r_gen;
  assign stable     = r_stable;
  assign extinct    = r_extinct;
  assign halted     = (r_state == HALTED);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_gol_array.sv
// Bench for gol_array on an 8x8 grid with a 6-bit generation counter.
// A neighbour-counting reference model tracks the array every cycle; directed
// scenarios add literal expectations for well-known patterns.
module tb_gol_array;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int GW   = 6;
  localparam int N    = W * H;
  localparam int GMAX = (1 << GW) - 1;

  localparam logic [N-1:0] VBAR   = 64'h0000_0000_0404_0400; // col 2, rows 1-3
  localparam logic [N-1:0] HBAR   = 64'h0000_0000_000E_0000; // row 2, cols 1-3
  localparam logic [N-1:0] GLIDER = 64'h0000_0000_0007_0402; // (0,1) (1,2) (2,0..2)
  localparam logic [N-1:0] BLOCK  = 64'h0000_0018_1800_0000; // rows 3-4, cols 3-4
  localparam logic [N-1:0] SINGLE = 64'h0000_0000_0800_0000; // (3,3)

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [N-1:0]  init_cells;
  logic          wrap_mode;
  logic          run;
  logic          step;
  logic          halt_on_stable;
  logic [N-1:0]  cells;
  logic [GW-1:0] generation;
  logic          stable;
  logic          extinct;
  logic          halted;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  gol_array #(
    .WIDTH  (W),
    .HEIGHT (H),
    .GEN_W  (GW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .init_cells     (init_cells),
    .wrap_mode      (wrap_mode),
    .run            (run),
    .step           (step),
    .halt_on_stable (halt_on_stable),
    .cells          (cells),
    .generation     (generation),
    .stable         (stable),
    .extinct        (extinct),
    .halted         (halted),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Straight neighbour count over the grid, coordinates folded or discarded.
  function automatic logic [N-1:0] life(input logic [N-1:0] g, input bit wrap);
    logic [N-1:0] res;
    int cnt;
    int rr;
    int cc;
    res = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!((dr == 0) && (dc == 0))) begin
              rr = r + dr;
              cc = c + dc;
              if (wrap) begin
                rr = (rr + H) % H;
                cc = (cc + W) % W;
              end
              if ((rr >= 0) && (rr < H) && (cc >= 0) && (cc < W) && g[rr*W+cc]) cnt++;
            end
          end
        end
        res[r*W+c] = (cnt == 3) || ((cnt == 2) && g[r*W+c]);
      end
    end
    return res;
  endfunction

  logic [N-1:0] m_cells;
  logic [N-1:0] m_nxt;
  int           m_gen;
  bit           m_stable;
  int           m_mode;   // 0 idle, 1 running, 2 halted
  bit           m_adv;

  always @(posedge clk) begin
    if (!rst) begin
      m_cells  = '0;
      m_gen    = 0;
      m_stable = 1'b0;
      m_mode   = 0;
    end else if (load) begin
      m_cells  = init_cells;
      m_gen    = 0;
      m_stable = 1'b0;
      m_mode   = 0;
    end else begin
      m_adv = 1'b0;
      if (m_mode == 0) begin
        if (run) begin
          m_adv  = 1'b1;
          m_mode = 1;
        end else if (step) begin
          m_adv  = 1'b1;
        end
      end else if (m_mode == 1) begin
        if (run) m_adv = 1'b1;
        else     m_mode = 0;
      end
      if (m_adv) begin
        m_nxt    = life(m_cells, wrap_mode);
        m_stable = (m_nxt == m_cells);
        if (halt_on_stable && ((m_nxt == m_cells) || (m_nxt == '0))) m_mode = 2;
        m_cells  = m_nxt;
        if (m_gen < GMAX) m_gen++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("cells",      64'(cells),      64'(m_cells));
      check("generation", 64'(generation), 64'(m_gen));
      check("stable",     64'(stable),     64'(m_stable));
      check("extinct",    64'(extinct),    64'(m_cells == '0));
      check("halted",     64'(halted),     64'(m_mode == 2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [N-1:0] pat, input bit wrap, input bit hos);
    load           = 1'b1;
    init_cells     = pat;
    wrap_mode      = wrap;
    halt_on_stable = hos;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // n advancing edges, then one edge with run low (back to IDLE, no advance).
  task automatic run_for(input int n);
    run = 1'b1;
    repeat (n) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] pat;

  initial begin
    rst = 1'b0; load = 1'b0; init_cells = '0; wrap_mode = 1'b0;
    run = 1'b0; step = 1'b0; halt_on_stable = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_cells",   64'(cells),      64'd0);
    check("reset_gen",     64'(generation), 64'd0);
    check("reset_extinct", 64'(extinct),    64'd1);
    check("reset_halted",  64'(halted),     64'd0);
    check("reset_stable",  64'(stable),     64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Blinker, dead border, single steps.
    do_load(VBAR, 1'b0, 1'b0);
    check("blink_load", 64'(cells), 64'(VBAR));
    do_step();
    check("blink_s1_cells", 64'(cells),      64'(HBAR));
    check("blink_s1_gen",   64'(generation), 64'd1);
    do_step();
    check("blink_s2_cells",  64'(cells),      64'(VBAR));
    check("blink_s2_gen",    64'(generation), 64'd2);
    check("blink_s2_stable", 64'(stable),     64'd0);
    repeat (2) @(negedge clk);
    check("blink_idle_hold", 64'(generation), 64'd2);

    // Glider on the torus returns home after 32 generations.
    do_load(GLIDER, 1'b1, 1'b0);
    run_for(32);
    check("glider_tor_cells", 64'(cells),      64'(GLIDER));
    check("glider_tor_gen",   64'(generation), 64'd32);

    // Same glider against a dead border does not return home.
    do_load(GLIDER, 1'b0, 1'b0);
    run_for(32);
    n_checks++;
    if (cells === GLIDER) begin
      n_fail++;
      $display("FAIL glider_dead_cells: got %0h expected anything but %0h", cells, GLIDER);
    end

    // Block still life halts after one advance; run/step are then ignored.
    do_load(BLOCK, 1'b0, 1'b1);
    run = 1'b1;
    @(negedge clk);
    check("block_stable", 64'(stable),     64'd1);
    check("block_halted", 64'(halted),     64'd1);
    check("block_gen",    64'(generation), 64'd1);
    repeat (3) @(negedge clk);
    run = 1'b0;
    do_step();
    check("block_gen_hold", 64'(generation), 64'd1);
    do_load(BLOCK, 1'b0, 1'b0);
    check("block_load_clears", 64'(halted), 64'd0);

    // Lone cell dies; with halt enabled the engine stops.
    do_load(SINGLE, 1'b1, 1'b1);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("single_cells",   64'(cells),   64'd0);
    check("single_extinct", 64'(extinct), 64'd1);
    check("single_halted",  64'(halted),  64'd1);
    do_load(SINGLE, 1'b1, 1'b0);
    run = 1'b1;
    @(negedge clk);
    check("single_nh_stable1", 64'(stable), 64'd0);
    @(negedge clk);
    check("single_nh_gen2",    64'(generation), 64'd2);
    check("single_nh_stable2", 64'(stable),     64'd1);
    check("single_nh_halted",  64'(halted),     64'd0);
    run = 1'b0;
    @(negedge clk);

    // Counter saturation while the blinker keeps oscillating.
    do_load(VBAR, 1'b1, 1'b0);
    run = 1'b1;
    repeat (70) @(negedge clk);
    check("sat_gen",   64'(generation), 64'(GMAX));
    check("sat_cells", 64'(cells),      64'(VBAR));
    @(negedge clk);
    check("sat_gen2",   64'(generation), 64'(GMAX));
    check("sat_cells2", 64'(cells),      64'(HBAR));
    run = 1'b0;
    @(negedge clk);

    // Reset mid-run with load also asserted.
    do_load(VBAR, 1'b0, 1'b0);
    run = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_gen5", 64'(generation), 64'd5);
    rst = 1'b0; load = 1'b1; init_cells = GLIDER;
    @(negedge clk);
    check("mid_rst_cells",   64'(cells),      64'd0);
    check("mid_rst_gen",     64'(generation), 64'd0);
    check("mid_rst_extinct", 64'(extinct),    64'd1);
    check("mid_rst_halted",  64'(halted),     64'd0);
    rst = 1'b1; load = 1'b0; run = 1'b0;
    @(negedge clk);
    check("mid_rst_idle_gen", 64'(generation), 64'd0);

    // Randomised control and patterns against the model.
    for (int t = 0; t < 40; t++) begin
      pat = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) pat = pat & {$urandom, $urandom};
      do_load(pat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(5, 25)) begin
        run  = ($urandom_range(0, 3) != 0);
        step = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 9) == 0) wrap_mode = ~wrap_mode;
        if ($urandom_range(0, 14) == 0) halt_on_stable = ~halt_on_stable;
        load = ($urandom_range(0, 24) == 0);
        init_cells = {$urandom, $urandom};
        @(negedge clk);
      end
      run = 1'b0; step = 1'b0; load = 1'b0;
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
